// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: round-robin grant of up to N_WRITE_PORTS
// distinct-address writebacks per cycle onto registered write ports.
module regfile_wr_arbiter #(
    parameter int N_SRCS        = 4,
    parameter int N_WRITE_PORTS = 2,
    parameter int ENTRY_WIDTH   = 32,
    parameter int N_ENTRIES     = 32,
    localparam int PTR_WIDTH    = $clog2(N_ENTRIES)
) (
    input  logic                                        clk,
    input  logic                                        rst_aL,
    input  logic [N_SRCS-1:0]                           src_valid,
    output logic [N_SRCS-1:0]                           src_ready,
    input  logic [N_SRCS-1:0][PTR_WIDTH-1:0]            src_addr,
    input  logic [N_SRCS-1:0][ENTRY_WIDTH-1:0]          src_data,
    output logic [N_WRITE_PORTS-1:0]                    wr_en,
    output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]     wr_addr,
    output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]   wr_data
);

    localparam int SW = $clog2(N_SRCS);

    logic [SW-1:0]                                 rr_ptr;
    logic [SW-1:0]                                 rr_nxt;
    logic [N_WRITE_PORTS-1:0]                      g_en;
    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]       g_addr;
    logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]     g_data;
    logic [SW-1:0]                                 idx;
    int                                            pos;
    logic                                          clash;
    logic                                          take;

    // Ports fill lowest-first, so the k-th grant in scan order lands on port k.
    always_comb begin
        src_ready = '0;
        g_en      = '0;
        g_addr    = '0;
        g_data    = '0;
        rr_nxt    = rr_ptr;
        idx       = '0;
        pos       = 0;
        clash     = 1'b0;
        take      = 1'b0;
        for (int j = 0; j < N_SRCS; j++) begin
            pos = int'(rr_ptr) + j;
            if (pos >= N_SRCS) begin
                pos = pos - N_SRCS;
            end
            idx = SW'(pos);
            if (src_valid[idx] && src_addr[idx] == '0) begin
                src_ready[idx] = 1'b1;
            end else if (src_valid[idx]) begin
                clash = 1'b0;
                for (int k = 0; k < N_WRITE_PORTS; k++) begin
                    if (g_en[k] && g_addr[k] == src_addr[idx]) begin
                        clash = 1'b1;
                    end
                end
                take = !clash;
                for (int k = 0; k < N_WRITE_PORTS; k++) begin
                    if (take && !g_en[k]) begin
                        g_en[k]        = 1'b1;
                        g_addr[k]      = src_addr[idx];
                        g_data[k]      = src_data[idx];
                        src_ready[idx] = 1'b1;
                        take           = 1'b0;
                        if (idx == SW'(N_SRCS - 1)) begin
                            rr_nxt = '0;
                        end else begin
                            rr_nxt = idx + 1'b1;
                        end
                    end
                end
            end
        end
        if (!rst_aL) begin
            src_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            rr_ptr  <= '0;
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            rr_ptr  <= rr_nxt;
            wr_en   <= g_en;
            wr_addr <= g_addr;
            wr_data <= g_data;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a queue-based reference model.
module tb_regfile_wr_arbiter;

    localparam int NS = 4;
    localparam int NW = 2;
    localparam int EW = 32;
    localparam int NE = 32;
    localparam int PW = 5;

    localparam logic [31:0] DA = 32'hAAAA_0001;
    localparam logic [31:0] DB = 32'hBBBB_0002;
    localparam logic [31:0] DC = 32'hCCCC_0003;
    localparam logic [31:0] DD = 32'hDDDD_0004;

    logic clk = 1'b0;
    logic rst_aL = 1'b0;
    always #5 clk = ~clk;

    logic [NS-1:0]              src_valid = '0;
    logic [NS-1:0]              src_ready;
    logic [NS-1:0][PW-1:0]      src_addr = '0;
    logic [NS-1:0][EW-1:0]      src_data = '0;
    logic [NW-1:0]              wr_en;
    logic [NW-1:0][PW-1:0]      wr_addr;
    logic [NW-1:0][EW-1:0]      wr_data;

    int n_vec = 0;
    int n_err = 0;

    int                     m_ptr = 0;
    int                     n_ptr = 0;
    logic [NS-1:0]          m_ready;
    logic [NW-1:0]          m_en, n_en;
    logic [NW-1:0][PW-1:0]  m_addr, n_addr;
    logic [NW-1:0][EW-1:0]  m_data, n_data;

    regfile_wr_arbiter #(
        .N_SRCS(NS), .N_WRITE_PORTS(NW),
        .ENTRY_WIDTH(EW), .N_ENTRIES(NE)
    ) dut (
        .clk(clk), .rst_aL(rst_aL),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_addr(src_addr), .src_data(src_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Rotate source list from the pointer, then take the first distinct
    // nonzero addresses until the ports run out.
    task automatic model_eval();
        int order[$];
        int won[$];
        int s;
        bit dup;
        m_ready = '0;
        n_en    = '0;
        n_addr  = '0;
        n_data  = '0;
        n_ptr   = m_ptr;
        for (int j = 0; j < NS; j++) order.push_back((m_ptr + j) % NS);
        foreach (order[i]) begin
            s = order[i];
            if (!src_valid[s]) continue;
            if (src_addr[s] == 0) begin
                m_ready[s] = 1'b1;
                continue;
            end
            if (won.size() == NW) continue;
            dup = 0;
            foreach (won[w]) if (src_addr[won[w]] == src_addr[s]) dup = 1;
            if (dup) continue;
            m_ready[s] = 1'b1;
            n_en[won.size()]   = 1'b1;
            n_addr[won.size()] = src_addr[s];
            n_data[won.size()] = src_data[s];
            won.push_back(s);
        end
        if (won.size() > 0) n_ptr = (won[won.size()-1] + 1) % NS;
        if (!rst_aL) begin
            m_ready = '0;
            n_en    = '0;
            n_addr  = '0;
            n_data  = '0;
            n_ptr   = 0;
        end
    endtask

    task automatic drive(input logic r, input logic [NS-1:0] v,
                         input logic [NS*PW-1:0] a,
                         input logic [NS*EW-1:0] d);
        @(negedge clk);
        rst_aL    = r;
        src_valid = v;
        src_addr  = a;
        src_data  = d;
        #1;
        model_eval();
        chk("ready_model", src_ready, m_ready);
    endtask

    task automatic tick();
        @(posedge clk);
        m_en   = n_en;
        m_addr = n_addr;
        m_data = n_data;
        m_ptr  = n_ptr;
        #1;
        chk("wr_en_model", wr_en, m_en);
        chk("wr_addr_model", wr_addr, m_addr);
        chk("wr_data_model", wr_data, m_data);
        chk("rr_ptr_model", dut.rr_ptr, m_ptr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with all sources requesting
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
            chk("reset_ready", src_ready, 4'b0000);
            tick();
        end
        chk("reset_en", wr_en, 2'b00);
        chk("reset_addr", wr_addr, 10'd0);
        chk("reset_data", wr_data, 64'd0);
        chk("reset_ptr", dut.rr_ptr, 0);

        // Round-robin fill
        drive(1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
        chk("rr_ready0", src_ready, 4'b0011);
        tick();
        chk("rr_en1", wr_en, 2'b11);
        chk("rr_addr1", wr_addr, {5'd2, 5'd1});
        chk("rr_data1", wr_data, {DB, DA});
        chk("rr_ptr1", dut.rr_ptr, 2);
        drive(1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
        chk("rr_ready1", src_ready, 4'b1100);
        tick();
        chk("rr_addr2", wr_addr, {5'd4, 5'd3});
        chk("rr_data2", wr_data, {DD, DC});
        chk("rr_ptr2", dut.rr_ptr, 0);
        drive(1'b1, 4'b0000, '0, '0);
        tick();
        chk("idle_en", wr_en, 2'b00);

        // Address conflict
        drive(1'b1, 4'b0111, {5'd0, 5'd6, 5'd5, 5'd5},
              {32'h0, 32'h2222, 32'h1111, 32'h0000_0c00});
        chk("cf_ready", src_ready, 4'b0101);
        tick();
        chk("cf_en", wr_en, 2'b11);
        chk("cf_addr", wr_addr, {5'd6, 5'd5});
        chk("cf_data", wr_data, {32'h2222, 32'h0000_0c00});
        chk("cf_ptr", dut.rr_ptr, 3);
        drive(1'b1, 4'b0010, {5'd0, 5'd6, 5'd5, 5'd5},
              {32'h0, 32'h2222, 32'h1111, 32'h0000_0c00});
        chk("cf_retry_ready", src_ready, 4'b0010);
        tick();
        chk("cf_retry_en", wr_en, 2'b01);
        chk("cf_retry_port0", {wr_addr[0], wr_data[0]}, {5'd5, 32'h1111});
        chk("cf_retry_ptr", dut.rr_ptr, 2);

        // Zero-address drop at rr_ptr=2
        drive(1'b1, 4'b0010, '0, {32'h0, 32'h0, 32'h5555, 32'h0});
        chk("zero_ready", src_ready, 4'b0010);
        tick();
        chk("zero_en", wr_en, 2'b00);
        chk("zero_ptr", dut.rr_ptr, 2);

        // Bring rr_ptr back to 0 via src3, then a single request
        drive(1'b1, 4'b1000, {5'd7, 15'd0}, {32'h7777, 96'd0});
        tick();
        chk("prep_ptr", dut.rr_ptr, 0);
        drive(1'b1, 4'b1000, {5'd31, 15'd0}, {32'hDEADBEEF, 96'd0});
        chk("single_ready", src_ready, 4'b1000);
        tick();
        chk("single_en", wr_en, 2'b01);
        chk("single_addr0", wr_addr[0], 5'd31);
        chk("single_data0", wr_data[0], 32'hDEADBEEF);
        chk("single_ptr", dut.rr_ptr, 0);

        // Reset mid-operation at rr_ptr=2
        drive(1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
        tick();
        chk("mid_pre_ptr", dut.rr_ptr, 2);
        drive(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
        chk("mid_rst_ready", src_ready, 4'b0000);
        tick();
        chk("mid_rst_en", wr_en, 2'b00);
        chk("mid_rst_ptr", dut.rr_ptr, 0);
        drive(1'b1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {DD, DC, DB, DA});
        chk("mid_rel_ready", src_ready, 4'b0011);
        tick();
        chk("mid_rel_addr", wr_addr, {5'd2, 5'd1});

        // Mixed zero drops and a triple-free conflict from rr_ptr=2
        drive(1'b1, 4'b1111, {5'd0, 5'd9, 5'd9, 5'd0}, {DD, DC, DB, DA});
        chk("mix_ready", src_ready, 4'b1101);
        tick();
        chk("mix_en", wr_en, 2'b01);
        chk("mix_port0", {wr_addr[0], wr_data[0]}, {5'd9, DC});
        chk("mix_ptr", dut.rr_ptr, 3);

        // All four on one address from rr_ptr=3: only src3 wins
        drive(1'b1, 4'b1111, {5'd12, 5'd12, 5'd12, 5'd12}, {DD, DC, DB, DA});
        chk("same_ready", src_ready, 4'b1000);
        tick();
        chk("same_en", wr_en, 2'b01);
        chk("same_ptr", dut.rr_ptr, 0);

        drive(1'b1, 4'b0000, '0, '0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
